// File: rtl/sweep_pkg.sv
// Shared types and constants for the combinational-block sweep controller.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned VEC_W       = 3;

  // Truth table of Z = A | (B & C), indexed by {A,B,C}.
  localparam logic [NUM_VECTORS-1:0] EXPECT_DEFAULT = 8'hF8;

  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/circuit_sweep_ctrl.sv
// Built-in self-check sequencer: walks {A,B,C} through 0..7, samples Z, scores against EXPECT.
// Done pulses 8*(SETTLE_CYCLES+1)+1 cycles after start; start/abort handshake, no backpressure.
module circuit_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned             SETTLE_CYCLES = 1,
  parameter logic [NUM_VECTORS-1:0]  EXPECT        = EXPECT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   z_i,
  output logic                   a_o,
  output logic                   b_o,
  output logic                   c_o,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] result,
  output logic [3:0]             mismatch_cnt,
  output logic [VEC_W-1:0]       first_fail_idx,
  output logic                   first_fail_vld
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  sweep_state_t           state_q;
  logic [VEC_W-1:0]       idx_q;
  logic [3:0]             cnt_q;
  logic [VEC_W-1:0]       vec_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pass_q;
  logic [NUM_VECTORS-1:0] result_q;
  logic [3:0]             mismatch_cnt_q;
  logic [VEC_W-1:0]       first_fail_idx_q;
  logic                   first_fail_vld_q;

  logic                   mis_hit;
  logic [3:0]             mismatch_cnt_d;
  logic [VEC_W-1:0]       idx_d;

  always_comb begin
    mis_hit        = (z_i != EXPECT[idx_q]);
    mismatch_cnt_d = mismatch_cnt_q + 4'(mis_hit);
    idx_d          = idx_q + VEC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      cnt_q            <= '0;
      vec_q            <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      result_q         <= '0;
      mismatch_cnt_q   <= '0;
      first_fail_idx_q <= '0;
      first_fail_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          vec_q  <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            state_q          <= SETTLE;
            idx_q            <= '0;
            cnt_q            <= '0;
            busy_q           <= 1'b1;
            pass_q           <= 1'b0;
            result_q         <= '0;
            mismatch_cnt_q   <= '0;
            first_fail_idx_q <= '0;
            first_fail_vld_q <= 1'b0;
          end
        end

        SETTLE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            vec_q   <= '0;
            pass_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        SAMPLE: begin
          // Abort wins even over the final sample: nothing is captured this cycle.
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            vec_q   <= '0;
            pass_q  <= 1'b0;
          end else begin
            result_q[idx_q] <= z_i;
            mismatch_cnt_q  <= mismatch_cnt_d;
            if (mis_hit && !first_fail_vld_q) begin
              first_fail_idx_q <= idx_q;
              first_fail_vld_q <= 1'b1;
            end
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= (mismatch_cnt_d == 4'd0);
            end else begin
              state_q <= SETTLE;
              idx_q   <= idx_d;
              cnt_q   <= '0;
              vec_q   <= idx_d;
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_o            = vec_q[2];
  assign b_o            = vec_q[1];
  assign c_o            = vec_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign result         = result_q;
  assign mismatch_cnt   = mismatch_cnt_q;
  assign first_fail_idx = first_fail_idx_q;
  assign first_fail_vld = first_fail_vld_q;

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// Bench for circuit_sweep_ctrl: S=1 and S=3 instances driving a modelled Z = A | (B & C) datapath.
module tb_circuit_sweep_ctrl;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] res;
    logic [3:0] cnt;
    logic [2:0] ffi;
    logic       ffv;
    logic       pass;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [3:0] cnt;
    logic [2:0] ffi;
    logic       ffv;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, abort1 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
  logic [1:0] mode = 2'd0;
  bit use3 = 1'b0;

  logic a1, b1, c1, busy1, done1, pass1, ffv1, z1;
  logic a3, b3, c3, busy3, done3, pass3, ffv3, z3;
  logic [7:0] result1, result3;
  logic [3:0] cnt1, cnt3;
  logic [2:0] ffi1, ffi3;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Datapath under test, with fault modes: 0 healthy, 1 stuck-1, 2 stuck-0, 3 inverted.
  function automatic logic zfun(input logic [1:0] m, input logic a, input logic b, input logic c);
    case (m)
      2'd0:    return a | (b & c);
      2'd1:    return 1'b1;
      2'd2:    return 1'b0;
      default: return ~(a | (b & c));
    endcase
  endfunction

  assign z1 = zfun(mode, a1, b1, c1);
  assign z3 = zfun(mode, a3, b3, c3);

  circuit_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .z_i(z1),
    .a_o(a1), .b_o(b1), .c_o(c1), .busy(busy1), .done(done1), .pass(pass1),
    .result(result1), .mismatch_cnt(cnt1), .first_fail_idx(ffi1), .first_fail_vld(ffv1)
  );

  circuit_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .z_i(z3),
    .a_o(a3), .b_o(b3), .c_o(c3), .busy(busy3), .done(done3), .pass(pass3),
    .result(result3), .mismatch_cnt(cnt3), .first_fail_idx(ffi3), .first_fail_vld(ffv3)
  );

  logic [2:0] s_vec, s_ffi;
  logic       s_busy, s_done, s_pass, s_ffv;
  logic [7:0] s_res;
  logic [3:0] s_cnt;
  assign s_vec  = use3 ? {a3, b3, c3} : {a1, b1, c1};
  assign s_busy = use3 ? busy3 : busy1;
  assign s_done = use3 ? done3 : done1;
  assign s_pass = use3 ? pass3 : pass1;
  assign s_res  = use3 ? result3 : result1;
  assign s_cnt  = use3 ? cnt3 : cnt1;
  assign s_ffi  = use3 ? ffi3 : ffi1;
  assign s_ffv  = use3 ? ffv3 : ffv1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (use3) start3 = v; else start1 = v;
  endtask

  task automatic drive_abort(input logic v);
    if (use3) abort3 = v; else abort1 = v;
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, "_result"}, s_res, e.res);
    chk({tag, "_mismatch_cnt"}, s_cnt, e.cnt);
    chk({tag, "_first_fail_idx"}, s_ffi, e.ffi);
    chk({tag, "_first_fail_vld"}, s_ffv, e.ffv);
    chk({tag, "_pass"}, s_pass, e.pass);
  endtask

  // Start pulse in cycle 0; cycle c is observed at the negedge following c rising edges.
  task automatic run_sweep(input bit sel3, input int restart_cyc, input int abort_cyc,
                           output int done_cyc);
    int period = sel3 ? 4 : 2;
    int lim = 8 * period + 6;
    int ndone = 0;
    exp_t e;
    use3 = sel3;
    done_cyc = -1;
    @(negedge clk);
    drive_start(1'b1);
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      drive_start(c == restart_cyc);
      drive_abort(c == abort_cyc);
      if (s_done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk_outputs("done", e);
        end else begin
          chk("unexpected_done", 32'd1, 32'd0);
        end
      end
      if (abort_cyc < 0 && c <= 8 * period) begin
        chk("vector_abc", 32'(s_vec), 32'((c - 1) / period));
        chk("busy_in_sweep", 32'(s_busy), 32'd1);
      end
      if (abort_cyc > 0 && c == abort_cyc + 1) begin
        chk("abort_busy", 32'(s_busy), 32'd0);
        chk("abort_abc", 32'(s_vec), 32'd0);
        chk("abort_pass", 32'(s_pass), 32'd0);
        chk("abort_result", 32'(s_res), 32'd0);
        chk("abort_mismatch_cnt", 32'(s_cnt), 32'd0);
      end
      if (done_cyc > 0 && c == done_cyc + 1) begin
        chk("after_done_busy", 32'(s_busy), 32'd0);
        chk("after_done_done", 32'(s_done), 32'd0);
      end
    end
    drive_start(1'b0);
    drive_abort(1'b0);
    chk("done_pulse_count", 32'(ndone), (abort_cyc < 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    vec_t tv[4];
    exp_t healthy;
    int dc;

    tv[0] = '{mode: 2'd0, res: 8'hF8, cnt: 4'd0, ffi: 3'd0, ffv: 1'b0, pass: 1'b1};
    tv[1] = '{mode: 2'd1, res: 8'hFF, cnt: 4'd3, ffi: 3'd0, ffv: 1'b1, pass: 1'b0};
    tv[2] = '{mode: 2'd2, res: 8'h00, cnt: 4'd5, ffi: 3'd3, ffv: 1'b1, pass: 1'b0};
    tv[3] = '{mode: 2'd3, res: 8'h07, cnt: 4'd8, ffi: 3'd0, ffv: 1'b1, pass: 1'b0};
    healthy = '{res: 8'hF8, cnt: 4'd0, ffi: 3'd0, ffv: 1'b0, pass: 1'b1};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_abc", 32'({a1, b1, c1}), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk_outputs("rst", '{res: 8'h00, cnt: 4'd0, ffi: 3'd0, ffv: 1'b0, pass: 1'b0});
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      mode = tv[i].mode;
      sb.push_back('{res: tv[i].res, cnt: tv[i].cnt, ffi: tv[i].ffi, ffv: tv[i].ffv,
                     pass: tv[i].pass});
      run_sweep(1'b0, -1, -1, dc);
      chk("done_cycle_s1", 32'(dc), 32'd17);
    end
    mode = 2'd0;

    sb.push_back(healthy);
    run_sweep(1'b1, -1, -1, dc);
    chk("done_cycle_s3", 32'(dc), 32'd33);

    sb.push_back(healthy);
    run_sweep(1'b0, 5, -1, dc);
    chk("done_cycle_restart_ignored", 32'(dc), 32'd17);

    run_sweep(1'b0, -1, 7, dc);
    chk("abort_no_done", 32'(dc), 32'hFFFF_FFFF);

    use3 = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_vector5", 32'({a1, b1, c1}), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("midrst_abc", 32'({a1, b1, c1}), 32'd0);
    chk("midrst_busy", 32'(busy1), 32'd0);
    chk("midrst_done", 32'(done1), 32'd0);
    chk_outputs("midrst", '{res: 8'h00, cnt: 4'd0, ffi: 3'd0, ffv: 1'b0, pass: 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    sb.push_back(healthy);
    run_sweep(1'b0, -1, -1, dc);
    chk("done_cycle_after_reset", 32'(dc), 32'd17);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/circuit_sweep_ctrl.md
Name: circuit_sweep_ctrl

Overview:
Sequencer that exercises the shared three-input combinational logic block (Z = A | (B & C)) across all 8 input combinations. Drives the block's inputs, waits a settle interval, samples Z, and compares it against an expected truth table. Reports a captured result vector, mismatch statistics and a pass flag through a start/busy/done handshake. Sits between a test/config master and the combinational datapath as its built-in self-check controller.

Parameters:
SETTLE_CYCLES, 1, cycles a vector is held before Z is sampled; legal range 1..15
EXPECT, 8'hF8, expected Z per vector index {A,B,C}; bit i = Z for index i

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  cancel sweep; sampled only while busy
z_i  input  1  Z output of the datapath under control
a_o  output  1  A input to datapath, registered
b_o  output  1  B input to datapath, registered
c_o  output  1  C input to datapath, registered
busy  output  1  high from the cycle after start until DONE is left
done  output  1  one-cycle pulse on sweep completion
pass  output  1  sweep completed with zero mismatches
result  output  8  captured Z; bit i = sample for vector i
mismatch_cnt  output  4  number of result bits differing from EXPECT (0..8)
first_fail_idx  output  3  lowest vector index that mismatched
first_fail_vld  output  1  first_fail_idx is valid

Behaviour:
- Reset (async, rst_n=0): state IDLE; a_o/b_o/c_o=0, busy=0, done=0, pass=0, result=0, mismatch_cnt=0, first_fail_idx=0, first_fail_vld=0, idx=0, settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE. Encoding is a 2-bit enum.
- IDLE: a/b/c held at 0. If start=1, then next cycle: SETTLE, idx=0, {a_o,b_o,c_o}=3'b000, busy=1, and result, mismatch_cnt, first_fail_* and pass cleared.
- SETTLE: {a_o,b_o,c_o}={idx}; settle counter counts SETTLE_CYCLES cycles, then moves to SAMPLE.
- SAMPLE (1 cycle): result[idx]<=z_i. If z_i != EXPECT[idx]: mismatch_cnt+1, and if first_fail_vld=0, first_fail_idx<=idx and first_fail_vld<=1. If idx=7, go to DONE. Otherwise idx+1, reload counter, go to SETTLE, and drive the new vector on the same edge.
- DONE (1 cycle): done=1, pass=(mismatch_cnt==0), busy=1. Next cycle: IDLE, busy=0, done=0.
- Latency: with start sampled in cycle 0, done is high in cycle 8*(SETTLE_CYCLES+1)+1. For S=1 that is cycle 17.
- start while not IDLE is ignored. start held high continuously re-launches a sweep from IDLE after each DONE.
- abort while in SETTLE or SAMPLE: next cycle IDLE, busy=0, a/b/c=0, no done pulse, pass=0. Partial result and statistics remain readable. The abort takes effect even if a SAMPLE in the same cycle would complete the sweep.
- abort in DONE is ignored. abort has priority over start.
- Outputs result, pass, mismatch_cnt and first_fail_* hold their values until the next accepted start or reset.
- rst_n asserted mid-sweep forces the reset values immediately, with no done pulse.
- mismatch_cnt cannot exceed 8, so no wrap is possible. idx is 3 bits and only increments while below 7.

Decomposition:
- Shared package sweep_pkg holds:
  - sweep_state_t enum (IDLE, SETTLE, SAMPLE, DONE);
  - NUM_VECTORS=8 and VEC_W=3;
  - default EXPECT constant 8'hF8.
- No sub-module is required. The settle counter and the FSM both live in circuit_sweep_ctrl.
- The bench instantiates the existing combinational block between a/b/c_o and z_i.

Test Plan:
- Healthy datapath, S=1, start pulse in cycle 0 -> done in cycle 17; result=8'hF8, pass=1, mismatch_cnt=0, first_fail_vld=0; a/b/c steps through 000..111.
- z_i forced to 1 -> result=8'hFF, mismatch_cnt=3, first_fail_idx=0, first_fail_vld=1, pass=0.
- S=3, healthy datapath -> done in cycle 33; each vector held 3 cycles before its SAMPLE cycle.
- Second start pulse at cycle 5 of a running sweep -> ignored; single done at cycle 17, results identical to the healthy run.
- abort asserted during SETTLE of vector 3 -> IDLE next cycle, no done, busy=0, result[2:0]=3'b000 captured, pass=0.
- rst_n pulsed low during vector 5 -> all outputs return to reset values within the same cycle; a new start gives a full sweep with done at cycle 17 after that start.
